// File: rtl/alu_sequencer.sv
// Issuing side of the ALU interface: decodes one instruction at a time, drives the ALU for
// exactly one cycle, and writes the returned result and flags into a small register file.
module alu_sequencer #(
    parameter int DATA_W = 8,
    parameter int NREG   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       instr,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_opcode,
    output logic              alu_enable,
    input  logic [DATA_W-1:0] alu_op,
    input  logic              alu_carry,
    input  logic              alu_zero,
    output logic              done,
    output logic              done_err,
    output logic [DATA_W-1:0] result,
    output logic [1:0]        result_rd,
    output logic              carry_flag,
    output logic              zero_flag,
    input  logic [1:0]        rd_sel,
    output logic [DATA_W-1:0] rd_data
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

    localparam logic [3:0] OP_LDI = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_DIV = 4'h3;
    localparam logic [3:0] OP_ILL = 4'h6;

    state_t state;
    state_t state_nxt;

    logic [DATA_W-1:0] rf [NREG];

    logic [3:0]        op_in;
    logic [1:0]        rd_in;
    logic [1:0]        ra_in;
    logic [1:0]        rb_in;
    logic              is_ldi_in;
    logic              illegal_in;
    logic              accept;

    logic [1:0]        rd_p0;
    logic [DATA_W-1:0] imm_p0;
    logic              is_ldi_p0;
    logic              err_p0;
    logic [DATA_W-1:0] cap_data;

    assign op_in      = instr[15:12];
    assign rd_in      = instr[11:10];
    assign ra_in      = instr[9:8];
    assign rb_in      = instr[7:6];
    assign is_ldi_in  = (op_in == OP_LDI);
    // Divide-by-zero is caught here so the ALU is never asked to divide by zero.
    assign illegal_in = (op_in == OP_ILL) || ((op_in == OP_DIV) && (rf[rb_in] == '0));
    assign accept     = (state == IDLE) && in_valid;
    assign cap_data   = is_ldi_p0 ? imm_p0 : alu_op;
    assign rd_data    = rf[rd_sel];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        in_ready   = 1'b0;
        alu_enable = 1'b0;
        done       = 1'b0;
        done_err   = 1'b0;
        case (state)
            IDLE: begin
                in_ready = !rst;
                if (in_valid) begin
                    if (is_ldi_in) begin
                        state_nxt = CAPTURE;
                    end else if (illegal_in) begin
                        state_nxt = RESP;
                    end else begin
                        state_nxt = ISSUE;
                    end
                end
            end
            ISSUE: begin
                alu_enable = 1'b1;
                state_nxt  = CAPTURE;
            end
            CAPTURE: begin
                state_nxt = RESP;
            end
            RESP: begin
                done      = 1'b1;
                done_err  = err_p0;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Accept stage: operands are latched here, so rd may safely alias ra/rb.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a      <= '0;
            alu_b      <= '0;
            alu_opcode <= '0;
            rd_p0      <= '0;
            imm_p0     <= '0;
            is_ldi_p0  <= 1'b0;
            err_p0     <= 1'b0;
        end else if (accept) begin
            rd_p0     <= rd_in;
            imm_p0    <= DATA_W'(instr[7:0]);
            is_ldi_p0 <= is_ldi_in;
            err_p0    <= illegal_in;
            if (!is_ldi_in && !illegal_in) begin
                alu_a      <= rf[ra_in];
                alu_b      <= rf[rb_in];
                alu_opcode <= op_in;
            end
        end
    end

    // Capture stage: write-back of result and architectural flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                rf[i] <= '0;
            end
            result     <= '0;
            result_rd  <= '0;
            carry_flag <= 1'b0;
            zero_flag  <= 1'b0;
        end else if (state == CAPTURE) begin
            rf[rd_p0] <= cap_data;
            result    <= cap_data;
            result_rd <= rd_p0;
            if (!is_ldi_p0) begin
                zero_flag <= alu_zero;
                if ((alu_opcode == OP_ADD) || (alu_opcode == OP_SUB)) begin
                    carry_flag <= alu_carry;
                end
            end
        end
    end

endmodule
